// File: rtl/serial_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_bus_arbiter
//
// Request/grant sequencer for the two-master serial bus. It grants m1 or m2,
// drives the address/data mux select, and handles split transactions from
// slave 3. When slave 3 splits, the owning master is parked and the bus is
// handed to the other master. The parked master is resumed once the slave
// reports ready and the bus is idle.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a grant-hold counter forces a release after TIMEOUT_CYCLES
//   consecutive grant cycles and pulses timeout_err. The offending master is
//   then masked until its breq falls once. When undefined, a grant is held for
//   as long as breq stays high, and timeout_err is tied low.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rstn         asynchronous active-low reset
//   m1_breq      master 1 bus request (level, held for the whole transaction)
//   m2_breq      master 2 bus request
//   m1_bgrant    grant to master 1
//   m2_bgrant    grant to master 2
//   m1_split     master 1 parked by a split (level)
//   m2_split     master 2 parked by a split (level)
//   msel         mux select, 0 = m1, 1 = m2; holds the last owner while idle
//   bus_busy     high while any grant is active
//   s_split      split request from slave 3, honoured only during a grant
//   s_ready      slave 3 ready to complete the split transaction
//   split_grant  to slave 3: the current owner is a resumed master
//   timeout_err  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module serial_bus_arbiter #(
    parameter bit          RR_EN          = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic m1_breq,
    input  logic m2_breq,
    output logic m1_bgrant,
    output logic m2_bgrant,
    output logic m1_split,
    output logic m2_split,
    output logic msel,
    output logic bus_busy,
    input  logic s_split,
    input  logic s_ready,
    output logic split_grant,
    output logic timeout_err
);

    // The hold counter must be able to reach TIMEOUT_CYCLES.
    if (CNT_WIDTH < 32 && TIMEOUT_CYCLES >= (32'd1 << CNT_WIDTH)) begin : g_cfg_check
        $error("serial_bus_arbiter: TIMEOUT_CYCLES does not fit in CNT_WIDTH");
    end

    // Master index: bit 0 is m1, bit 1 is m2.
    localparam logic OWNER_M1 = 1'b0;
    localparam logic OWNER_M2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_split_pend, w_split_pend_nxt;
    logic       r_split_owner, w_split_owner_nxt;
    logic       r_last_owner, w_last_owner_nxt;
    logic [1:0] r_split_flag, w_split_flag_nxt;
    logic       r_resume, w_resume_nxt;          // current grant is a split resume
    logic       r_timeout_err, w_timeout_nxt;
    logic       r_m1_bgrant, w_m1_bgrant_nxt;
    logic       r_m2_bgrant, w_m2_bgrant_nxt;
    logic       r_bus_busy, w_bus_busy_nxt;
    logic       r_msel, w_msel_nxt;

    logic [1:0] w_breq;
    logic [1:0] w_req_vld;
    logic [1:0] w_to_mask;
    logic       w_own_idx;
    logic       w_timeout_hit;

    assign w_breq    = {m2_breq, m1_breq};
    assign w_own_idx = (r_state == OWN_M2);
    // Parked masters and timed-out masters do not compete for the bus.
    assign w_req_vld = w_breq & ~r_split_flag & ~w_to_mask;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] r_hold_cnt;
    logic [CNT_WIDTH-1:0] w_hold_inc;
    logic [1:0]           r_to_mask;

    assign w_hold_inc    = r_hold_cnt + CNT_WIDTH'(1);
    // Fires during the TIMEOUT_CYCLES-th grant cycle so the grant is high for
    // exactly TIMEOUT_CYCLES cycles.
    assign w_timeout_hit = (r_state != IDLE) && (w_hold_inc == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign w_to_mask     = r_to_mask;

    // Every grant passes through IDLE first, so clearing in IDLE gives a
    // zeroed counter on the first cycle of every grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold_cnt <= '0;
            r_to_mask  <= 2'b00;
        end else begin
            r_hold_cnt <= (r_state == IDLE) ? '0 : w_hold_inc;
            // A timed-out master stays masked until its breq falls once.
            r_to_mask  <= w_breq & (r_to_mask |
                          (w_timeout_nxt ? {w_own_idx, ~w_own_idx} : 2'b00));
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign w_to_mask     = 2'b00;
`endif

    // State register: FSM state, side state and all registered outputs.
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_split_pend  <= 1'b0;
            r_split_owner <= OWNER_M1;
            r_last_owner  <= OWNER_M2;  // m1 wins the first round-robin pick
            r_split_flag  <= 2'b00;
            r_resume      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_m1_bgrant   <= 1'b0;
            r_m2_bgrant   <= 1'b0;
            r_bus_busy    <= 1'b0;
            r_msel        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_split_pend  <= w_split_pend_nxt;
            r_split_owner <= w_split_owner_nxt;
            r_last_owner  <= w_last_owner_nxt;
            r_split_flag  <= w_split_flag_nxt;
            r_resume      <= w_resume_nxt;
            r_timeout_err <= w_timeout_nxt;
            r_m1_bgrant   <= w_m1_bgrant_nxt;
            r_m2_bgrant   <= w_m2_bgrant_nxt;
            r_bus_busy    <= w_bus_busy_nxt;
            r_msel        <= w_msel_nxt;
        end
    end

    // Next-state and side-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt       = r_state;
        w_split_pend_nxt  = r_split_pend;
        w_split_owner_nxt = r_split_owner;
        w_last_owner_nxt  = r_last_owner;
        w_split_flag_nxt  = r_split_flag;
        w_resume_nxt      = r_resume;
        w_timeout_nxt     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_resume_nxt = 1'b0;
                if (r_split_pend && s_ready) begin
                    // A resume beats any new request.
                    w_state_nxt                     = r_split_owner ? OWN_M2 : OWN_M1;
                    w_resume_nxt                    = 1'b1;
                    w_split_pend_nxt                = 1'b0;
                    w_split_flag_nxt[r_split_owner] = 1'b0;
                end else if (w_req_vld == 2'b11) begin
                    w_state_nxt = (RR_EN && r_last_owner == OWNER_M1) ? OWN_M2 : OWN_M1;
                end else if (w_req_vld[0]) begin
                    w_state_nxt = OWN_M1;
                end else if (w_req_vld[1]) begin
                    w_state_nxt = OWN_M2;
                end
            end

            OWN_M1, OWN_M2: begin
                if (!w_breq[w_own_idx]) begin
                    // A release beats a split arriving on the same cycle.
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = w_own_idx;
                    w_resume_nxt     = 1'b0;
                end else if (w_timeout_hit) begin
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = w_own_idx;
                    w_resume_nxt     = 1'b0;
                    w_timeout_nxt    = 1'b1;
                    if (r_resume) begin
                        w_split_pend_nxt = 1'b0;
                    end
                end else if (s_split && !r_split_pend && !r_resume) begin
                    // Only one split may be outstanding; later ones are ignored.
                    w_state_nxt                 = IDLE;
                    w_split_pend_nxt            = 1'b1;
                    w_split_owner_nxt           = w_own_idx;
                    w_split_flag_nxt[w_own_idx] = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        w_m1_bgrant_nxt = (w_state_nxt == OWN_M1);
        w_m2_bgrant_nxt = (w_state_nxt == OWN_M2);
        w_bus_busy_nxt  = (w_state_nxt != IDLE);
        w_msel_nxt      = r_msel;
        if (r_state == IDLE && w_state_nxt != IDLE) begin
            w_msel_nxt = (w_state_nxt == OWN_M2);
        end
    end

    assign m1_bgrant   = r_m1_bgrant;
    assign m2_bgrant   = r_m2_bgrant;
    assign m1_split    = r_split_flag[0];
    assign m2_split    = r_split_flag[1];
    assign msel        = r_msel;
    assign bus_busy    = r_bus_busy;
    assign split_grant = r_resume;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_serial_bus_arbiter
//
// Self-checking bench for serial_bus_arbiter. Expected grants (owner and
// whether the grant is a split resume) are queued when stimulus is driven and
// compared by a monitor when a grant starts. Directed checks cover reset,
// latency, round-robin vs fixed priority, split/resume, and async reset.
// A second instance with RR_EN=0 has its own request inputs.
// Build with +define+ARB_TIMEOUT_EN to exercise the timeout feature.
// -----------------------------------------------------------------------------
module tb_serial_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic [1:0] breq;
    logic [1:0] breq_fp;
    logic       s_split;
    logic       s_ready;

    logic m1_bgrant, m2_bgrant, m1_split, m2_split, msel, bus_busy, split_grant, timeout_err;
    logic fp_m1_bgrant, fp_m2_bgrant, fp_m1_split, fp_m2_split, fp_msel, fp_bus_busy;
    logic fp_split_grant, fp_timeout_err;

    always #5 clk = ~clk;

    serial_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rstn(rstn),
        .m1_breq(breq[0]), .m2_breq(breq[1]),
        .m1_bgrant(m1_bgrant), .m2_bgrant(m2_bgrant),
        .m1_split(m1_split), .m2_split(m2_split),
        .msel(msel), .bus_busy(bus_busy),
        .s_split(s_split), .s_ready(s_ready),
        .split_grant(split_grant), .timeout_err(timeout_err)
    );

    serial_bus_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_WIDTH(16)) u_dut_fp (
        .clk(clk), .rstn(rstn),
        .m1_breq(breq_fp[0]), .m2_breq(breq_fp[1]),
        .m1_bgrant(fp_m1_bgrant), .m2_bgrant(fp_m2_bgrant),
        .m1_split(fp_m1_split), .m2_split(fp_m2_split),
        .msel(fp_msel), .bus_busy(fp_bus_busy),
        .s_split(1'b0), .s_ready(1'b0),
        .split_grant(fp_split_grant), .timeout_err(fp_timeout_err)
    );

    typedef struct packed {
        logic owner;   // 0 = m1, 1 = m2
        logic sg;      // split_grant expected with this grant
    } exp_grant_t;

    exp_grant_t sb_q[$];
    exp_grant_t mon_e;
    int         n_checks  = 0;
    int         n_bad     = 0;
    int         to_pulses = 0;
    logic       prev_m1   = 1'b0;
    logic       prev_m2   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h required=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic owner, input logic sg);
        exp_grant_t e;
        e.owner = owner;
        e.sg    = sg;
        sb_q.push_back(e);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_m1_bgrant"},   32'(m1_bgrant),   0);
        check({tag, "_m2_bgrant"},   32'(m2_bgrant),   0);
        check({tag, "_m1_split"},    32'(m1_split),    0);
        check({tag, "_m2_split"},    32'(m2_split),    0);
        check({tag, "_msel"},        32'(msel),        0);
        check({tag, "_bus_busy"},    32'(bus_busy),    0);
        check({tag, "_split_grant"}, 32'(split_grant), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic apply_reset();
        breq    = 2'b00;
        breq_fp = 2'b00;
        s_split = 1'b0;
        s_ready = 1'b0;
        rstn    = 1'b0;
        step(2);
        rstn    = 1'b1;
    endtask

    // Wait (bounded) for a grant on the selected instance.
    task automatic wait_grant(input string tag, input bit fp, input int budget,
                              output logic owner);
        bit seen;
        seen  = 1'b0;
        owner = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (fp ? (fp_m1_bgrant | fp_m2_bgrant) : (m1_bgrant | m2_bgrant)) begin
                seen  = 1'b1;
                owner = fp ? fp_m2_bgrant : m2_bgrant;
                break;
            end
        end
        check({tag, "_grant_seen"}, 32'(seen), 1);
    endtask

    // Scoreboard monitor: compares each new grant against the queue head.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_m1 = 1'b0;
            prev_m2 = 1'b0;
        end else begin
            check("grant_exclusive", 32'(m1_bgrant & m2_bgrant), 0);
            check("no_back_to_back", 32'((prev_m1 & m2_bgrant) | (prev_m2 & m1_bgrant)), 0);
            if ((m1_bgrant | m2_bgrant) && !(prev_m1 | prev_m2)) begin
                check("sb_expect_pending", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_grant_vec", {30'd0, m2_bgrant, m1_bgrant},
                          mon_e.owner ? 32'd2 : 32'd1);
                    check("sb_msel",        32'(msel),        32'(mon_e.owner));
                    check("sb_split_grant", 32'(split_grant), 32'(mon_e.sg));
                    check("sb_bus_busy",    32'(bus_busy),    1);
                end
            end
            if (timeout_err) to_pulses++;
            prev_m1 = m1_bgrant;
            prev_m2 = m2_bgrant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic own;
        int   m1_cycles, m2_cycles, to_base;

        breq = 2'b00; breq_fp = 2'b00; s_split = 1'b0; s_ready = 1'b0;
        #1;

        // ---- 1: reset values and basic latency ----
        apply_reset();
        check_all_low("t1_reset");
        step(5);
        breq[0] = 1'b1;
        expect_grant(1'b0, 1'b0);
        check("t1_no_early_grant", 32'(m1_bgrant), 0);
        step(1);
        check("t1_m1_grant", 32'(m1_bgrant), 1);
        check("t1_msel",     32'(msel),      0);
        check("t1_busy",     32'(bus_busy),  1);
        step(14);
        check("t1_still_granted", 32'(m1_bgrant), 1);
        breq[0] = 1'b0;
        step(1);
        check("t1_release",   32'(m1_bgrant), 0);
        check("t1_busy_low",  32'(bus_busy),  0);
        check("t1_msel_hold", 32'(msel),      0);
        check("t1_sb_drain",  sb_q.size(),    0);

        // ---- 2a: round robin alternates m1, m2, m1, m2 ----
        apply_reset();
        expect_grant(1'b0, 1'b0); expect_grant(1'b1, 1'b0);
        expect_grant(1'b0, 1'b0); expect_grant(1'b1, 1'b0);
        breq = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_grant("t2_rr", 1'b0, 20, own);
            step(7);
            breq[own] = 1'b0;
            step(1);
            check("t2_rr_idle_gap", {30'd0, m2_bgrant, m1_bgrant}, 0);
            if (r < 3) breq[own] = 1'b1;
            else       breq      = 2'b00;
        end
        step(2);
        check("t2_rr_sb_drain", sb_q.size(), 0);

        // ---- 2b: fixed priority always serves m1 ----
        apply_reset();
        breq_fp = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_grant("t2_fp", 1'b1, 20, own);
            check("t2_fp_owner_m1", 32'(own), 0);
            step(7);
            breq_fp[own] = 1'b0;
            step(1);
            check("t2_fp_idle_gap", {30'd0, fp_m2_bgrant, fp_m1_bgrant}, 0);
            if (r < 3) breq_fp[own] = 1'b1;
            else       breq_fp      = 2'b00;
        end
        step(2);

        // ---- 3: split parks m1, m2 served, resume after m2 releases ----
        apply_reset();
        breq[0] = 1'b1;
        expect_grant(1'b0, 1'b0);
        wait_grant("t3_m1", 1'b0, 5, own);
        step(2);
        s_split = 1'b1;
        step(1);
        s_split = 1'b0;
        check("t3_m1_dropped", 32'(m1_bgrant), 0);
        check("t3_m1_split",   32'(m1_split),  1);
        check("t3_busy_low",   32'(bus_busy),  0);
        breq[1] = 1'b1;
        expect_grant(1'b1, 1'b0);
        step(1);
        check("t3_m2_grant",   32'(m2_bgrant), 1);
        check("t3_msel_m2",    32'(msel),      1);
        check("t3_m1_parked",  32'(m1_split),  1);
        s_ready = 1'b1;
        step(3);
        check("t3_no_resume_yet", 32'(m1_bgrant), 0);
        check("t3_m2_still",      32'(m2_bgrant), 1);
        expect_grant(1'b0, 1'b1);
        breq[1] = 1'b0;
        step(1);
        check("t3_m2_release", 32'(m2_bgrant), 0);
        step(1);
        check("t3_resume_m1",    32'(m1_bgrant),   1);
        check("t3_split_grant",  32'(split_grant), 1);
        check("t3_m1_split_clr", 32'(m1_split),    0);
        check("t3_msel_m1",      32'(msel),        0);
        s_ready = 1'b0;
        s_split = 1'b1;
        step(2);
        s_split = 1'b0;
        check("t3_split_ignored_grant", 32'(m1_bgrant),   1);
        check("t3_split_ignored_flag",  32'(m1_split),    0);
        check("t3_split_grant_held",    32'(split_grant), 1);
        breq[0] = 1'b0;
        step(1);
        check("t3_final_release", 32'(m1_bgrant),   0);
        check("t3_sg_drop",       32'(split_grant), 0);
        check("t3_sb_drain",      sb_q.size(),      0);

        // ---- 4: resume beats a new request in the same IDLE cycle ----
        apply_reset();
        breq[1] = 1'b1;
        expect_grant(1'b1, 1'b0);
        wait_grant("t4_m2", 1'b0, 5, own);
        step(1);
        s_split = 1'b1;
        step(1);
        s_split = 1'b0;
        check("t4_m2_parked",  32'(m2_split),  1);
        check("t4_m2_dropped", 32'(m2_bgrant), 0);
        s_ready = 1'b1;
        breq[0] = 1'b1;
        expect_grant(1'b1, 1'b1);
        expect_grant(1'b0, 1'b0);
        step(1);
        check("t4_resume_first", 32'(m2_bgrant),   1);
        check("t4_m1_waits",     32'(m1_bgrant),   0);
        check("t4_split_grant",  32'(split_grant), 1);
        s_ready = 1'b0;
        step(2);
        breq[1] = 1'b0;
        step(1);
        check("t4_idle_gap", {30'd0, m2_bgrant, m1_bgrant}, 0);
        step(1);
        check("t4_m1_after",  32'(m1_bgrant),   1);
        check("t4_m1_not_sg", 32'(split_grant), 0);
        breq = 2'b00;
        step(2);
        check("t4_sb_drain", sb_q.size(), 0);

        // ---- 5: long hold, with or without timeout ----
        apply_reset();
        to_base   = to_pulses;
        m1_cycles = 0;
        m2_cycles = 0;
        breq = 2'b11;
        expect_grant(1'b0, 1'b0);
        expect_grant(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (m1_bgrant) m1_cycles++;
            if (m2_bgrant) m2_cycles++;
            if (m2_cycles == 4) breq[1] = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        check("t5_grant_len",  m1_cycles,             16);
        check("t5_pulse_once", to_pulses - to_base,   1);
        check("t5_m2_served",  m2_cycles,             4);
        check("t5_m1_masked",  32'(m1_bgrant),        0);
        breq[0] = 1'b0;
        step(1);
        breq[0] = 1'b1;
        expect_grant(1'b0, 1'b0);
        step(1);
        check("t5_regrant", 32'(m1_bgrant), 1);
        breq = 2'b00;
        step(2);
`else
        check("t5_grant_held", m1_cycles,           40);
        check("t5_m2_waits",   m2_cycles,           0);
        check("t5_no_timeout", to_pulses - to_base, 0);
        breq[0] = 1'b0;
        step(2);
        check("t5_m2_after", 32'(m2_bgrant), 1);
        breq = 2'b00;
        step(2);
`endif
        check("t5_sb_drain", sb_q.size(), 0);

        // ---- 6: async reset mid-grant with a split pending ----
        apply_reset();
        breq[0] = 1'b1;
        expect_grant(1'b0, 1'b0);
        wait_grant("t6_m1", 1'b0, 5, own);
        s_split = 1'b1;
        step(1);
        s_split = 1'b0;
        breq[1] = 1'b1;
        expect_grant(1'b1, 1'b0);
        step(1);
        check("t6_m2_own",    32'(m2_bgrant), 1);
        check("t6_m1_parked", 32'(m1_split),  1);
        step(2);
        #2;
        rstn = 1'b0;
        #1;
        check_all_low("t6_async");
        breq[1] = 1'b0;
        s_ready = 1'b1;
        step(1);
        check("t6_held_in_reset", 32'(bus_busy), 0);
        rstn = 1'b1;
        expect_grant(1'b0, 1'b0);
        step(1);
        check("t6_m1_fresh_grant",     32'(m1_bgrant),   1);
        check("t6_split_pend_cleared", 32'(split_grant), 0);
        s_ready = 1'b0;
        breq    = 2'b00;
        step(2);
        check("t6_sb_drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
